// File: rtl/multdiv_seq.sv
// Sequential WIDTH-bit signed/unsigned multiply (radix-2 shift-add) and divide (non-restoring).
// Define MULTDIV_SEQ_FAST_EXC_EN to finish divide-by-zero and signed MIN/-1 one cycle after start.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic             start;
  logic             a_neg_in, b_neg_in, div_zero_in, div_ovf_in, fast_exc;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  logic [CW-1:0]    cnt;
  logic             op_div, sgn_q, neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH+1:0] hi_q;    // partial product high half, or signed partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier shifting out / dividend out and quotient in
  logic [WIDTH-1:0] opnd_q;  // multiplicand or divisor magnitude

  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   rem_shift, hi_step;
  logic [WIDTH-1:0]   lo_step;
  logic               load_out, res_exc;
  logic [WIDTH-1:0]   res_lo, res_hi, rem_mag;
  logic [2*WIDTH-1:0] prod_mag, prod;

  assign start = ctrl_MULT ^ ctrl_DIV;
  assign busy  = (state != IDLE);

  always_comb begin
    a_neg_in    = ctrl_signed & data_operandA[WIDTH-1];
    b_neg_in    = ctrl_signed & data_operandB[WIDTH-1];
    a_mag_in    = a_neg_in ? -data_operandA : data_operandA;
    b_mag_in    = b_neg_in ? -data_operandB : data_operandB;
    div_zero_in = (data_operandB == '0);
    div_ovf_in  = ctrl_signed && (data_operandA == MIN_VAL) && (data_operandB == '1);
  end

`ifdef MULTDIV_SEQ_FAST_EXC_EN
  assign fast_exc = ctrl_DIV & (div_zero_in | div_ovf_in);
`else
  assign fast_exc = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = fast_exc ? DONE : RUN;
    end else begin
      case (state)
        RUN:     if (cnt == CW'(1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  // One iteration: shift-add for multiply, shift then add/subtract by remainder sign for divide.
  always_comb begin
    add_sum   = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
    hi_step   = '0;
    lo_step   = '0;
    if (op_div) begin
      hi_step = hi_q[WIDTH+1] ? rem_shift + {2'b00, opnd_q} : rem_shift - {2'b00, opnd_q};
      lo_step = {lo_q[WIDTH-2:0], ~hi_step[WIDTH+1]};
    end else begin
      hi_step = {2'b00, add_sum[WIDTH:1]};
      lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Completion values: remainder correction, sign fix-up and exceptions.
  always_comb begin
    load_out = (state == DONE) && !start;
    prod_mag = {hi_q[WIDTH-1:0], lo_q};
    prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
    rem_mag  = hi_q[WIDTH+1] ? hi_q[WIDTH-1:0] + opnd_q : hi_q[WIDTH-1:0];
    res_lo   = '0;
    res_hi   = '0;
    res_exc  = 1'b0;
    if (!op_div) begin
      res_lo  = prod[WIDTH-1:0];
      res_hi  = prod[2*WIDTH-1:WIDTH];
      res_exc = sgn_q ? (res_hi != {WIDTH{res_lo[WIDTH-1]}}) : (res_hi != '0);
    end else if (div_zero) begin
      res_exc = 1'b1;
    end else if (div_ovf) begin
      res_lo  = MIN_VAL;
      res_exc = 1'b1;
    end else begin
      res_lo = (neg_a ^ neg_b) ? -lo_q : lo_q;
      res_hi = neg_a ? -rem_mag : rem_mag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      op_div         <= 1'b0;
      sgn_q          <= 1'b0;
      neg_a          <= 1'b0;
      neg_b          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      opnd_q         <= '0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= load_out;
      if (start) begin
        cnt      <= CW'(WIDTH);
        op_div   <= ctrl_DIV;
        sgn_q    <= ctrl_signed;
        neg_a    <= a_neg_in;
        neg_b    <= b_neg_in;
        div_zero <= ctrl_DIV & div_zero_in;
        div_ovf  <= ctrl_DIV & div_ovf_in;
        hi_q     <= '0;
        lo_q     <= ctrl_DIV ? a_mag_in : b_mag_in;
        opnd_q   <= ctrl_DIV ? b_mag_in : a_mag_in;
      end else if (state == RUN) begin
        cnt  <= cnt - CW'(1);
        hi_q <= hi_step;
        lo_q <= lo_step;
      end
      if (load_out) begin
        data_result    <= res_lo;
        data_result_hi <= res_hi;
        data_exception <= res_exc;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: WIDTH=32 and WIDTH=8 instances checked every cycle against a
// transaction-level arithmetic model, plus hand-computed directed cases.
module tb_multdiv_seq;
  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exc;
  } res_t;

`ifdef MULTDIV_SEQ_FAST_EXC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int EXC_LAT32 = FAST ? 1 : 33;
  localparam int EXC_LAT8  = FAST ? 1 : 9;

  logic clock = 1'b0;
  logic reset;
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic        mult_in [2];
  logic        div_in [2];
  logic        sgn_in [2];

  logic [31:0] res32, hi32;
  logic        exc32, rdy32, busy32;
  logic [7:0]  res8, hi8;
  logic        exc8, rdy8, busy8;
  logic [31:0] res_w [2];
  logic [31:0] hi_w [2];
  logic        exc_w [2];
  logic        rdy_w [2];
  logic        busy_w [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  multdiv_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset),
    .data_operandA(op_a[0]), .data_operandB(op_b[0]),
    .ctrl_MULT(mult_in[0]), .ctrl_DIV(div_in[0]), .ctrl_signed(sgn_in[0]),
    .data_result(res32), .data_result_hi(hi32), .data_exception(exc32),
    .data_resultRDY(rdy32), .busy(busy32)
  );

  multdiv_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset),
    .data_operandA(op_a[1][7:0]), .data_operandB(op_b[1][7:0]),
    .ctrl_MULT(mult_in[1]), .ctrl_DIV(div_in[1]), .ctrl_signed(sgn_in[1]),
    .data_result(res8), .data_result_hi(hi8), .data_exception(exc8),
    .data_resultRDY(rdy8), .busy(busy8)
  );

  always_comb begin
    res_w[0] = res32;           hi_w[0] = hi32;           exc_w[0] = exc32;
    rdy_w[0] = rdy32;           busy_w[0] = busy32;
    res_w[1] = {24'd0, res8};   hi_w[1] = {24'd0, hi8};   exc_w[1] = exc8;
    rdy_w[1] = rdy8;            busy_w[1] = busy8;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int width_of(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic longint to_val(input logic [31:0] x, input int w, input logic sgn);
    longint v;
    v = longint'({32'd0, x}) & ((longint'(1) << w) - 1);
    if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic bit exc_case(input logic div, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b, input int w);
    longint va, vb;
    va = to_val(a, w, sgn);
    vb = to_val(b, w, sgn);
    return div && (vb == 0 || (sgn && va == -(longint'(1) << (w - 1)) && vb == -1));
  endfunction

  // Plain-arithmetic reference for one operation.
  function automatic res_t ref_op(input logic div, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b, input int w);
    res_t r;
    longint va, vb, p, q, m, mask;
    logic [63:0] pu;
    mask = (longint'(1) << w) - 1;
    va   = to_val(a, w, sgn);
    vb   = to_val(b, w, sgn);
    r    = '0;
    if (!div) begin
      p     = va * vb;
      pu    = p;
      r.lo  = 32'(pu & mask);
      r.hi  = 32'((pu >> w) & mask);
      r.exc = sgn ? (p < -(longint'(1) << (w - 1)) || p >= (longint'(1) << (w - 1)))
                  : (r.hi != 32'd0);
    end else if (vb == 0) begin
      r.exc = 1'b1;
    end else if (sgn && va == -(longint'(1) << (w - 1)) && vb == -1) begin
      r.lo  = 32'(longint'(1) << (w - 1));
      r.exc = 1'b1;
    end else begin
      q    = va / vb;
      m    = va % vb;
      r.lo = 32'(q & mask);
      r.hi = 32'(m & mask);
    end
    return r;
  endfunction

  // Transaction-level model: pending op completes a fixed latency after its start.
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   pend [2];
  bit   rdy_exp [2];
  int   done_at [2];
  res_t pv [2];
  res_t held [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; rdy_exp[i] = 1'b0; done_at[i] = 0; pv[i] = '0; held[i] = '0;
    end
    forever begin
      @(posedge clock);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        rdy_exp[i] = 1'b0;
        if (reset) begin
          pend[i] = 1'b0;
          held[i] = '0;
          chk_en  = 1'b1;
        end else if (mult_in[i] ^ div_in[i]) begin
          pend[i]    = 1'b1;
          pv[i]      = ref_op(div_in[i], sgn_in[i], op_a[i], op_b[i], width_of(i));
          done_at[i] = cyc + ((FAST && exc_case(div_in[i], sgn_in[i], op_a[i], op_b[i], width_of(i)))
                              ? 1 : width_of(i) + 1);
        end else if (pend[i] && cyc == done_at[i]) begin
          held[i]    = pv[i];
          pend[i]    = 1'b0;
          rdy_exp[i] = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("w%0d rdy", width_of(i)),  64'(rdy_w[i]),  64'(rdy_exp[i]));
          check($sformatf("w%0d busy", width_of(i)), 64'(busy_w[i]), 64'(pend[i]));
          check($sformatf("w%0d lo", width_of(i)),   64'(res_w[i]),  64'(held[i].lo));
          check($sformatf("w%0d hi", width_of(i)),   64'(hi_w[i]),   64'(held[i].hi));
          if (rdy_exp[i]) check($sformatf("w%0d exc", width_of(i)), 64'(exc_w[i]), 64'(held[i].exc));
        end
      end
    end
  end

  task automatic issue(input int i, input logic div, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b, input bit now);
    if (!now) begin
      @(posedge clock);
      #1;
    end
    op_a[i] = a; op_b[i] = b; sgn_in[i] = sgn; mult_in[i] = ~div; div_in[i] = div;
    @(posedge clock);
    #1;
    mult_in[i] = 1'b0; div_in[i] = 1'b0;
    op_a[i] = $urandom; op_b[i] = $urandom; sgn_in[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rdy(input int i, input int limit, output int lat);
    lat = -1;
    for (int n = 0; n <= limit; n++) begin
      @(negedge clock);
      if (rdy_w[i] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input int i, input logic div, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b, input bit now,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic eexc,
                        input int elat);
    int lat;
    issue(i, div, sgn, a, b, now);
    wait_rdy(i, 80, lat);
    check({name, " latency"}, 64'(lat), 64'(elat));
    check({name, " lo"},  64'(res_w[i]), 64'(elo));
    check({name, " hi"},  64'(hi_w[i]),  64'(ehi));
    check({name, " exc"}, 64'(exc_w[i]), 64'(eexc));
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, v;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = m;
      3:       v = 32'(longint'(1) << (w - 1));
      4:       v = m >> 1;
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  initial begin
    int n_rdy, n_busy, r;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_a[i] = '0; op_b[i] = '0; mult_in[i] = 1'b0; div_in[i] = 1'b0; sgn_in[i] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("reset lo",   64'(res_w[i]),  64'd0);
      check("reset hi",   64'(hi_w[i]),   64'd0);
      check("reset exc",  64'(exc_w[i]),  64'd0);
      check("reset rdy",  64'(rdy_w[i]),  64'd0);
      check("reset busy", 64'(busy_w[i]), 64'd0);
    end

    run_op("smul 7*-3",      0, 1'b0, 1'b1, 32'd7,         32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("umul 2^16*2^16", 0, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0,         32'd1,         1'b1, 33);
    run_op("sdiv -7/2",      0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("sdiv -7/0",      0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0,         1'b0, 32'd0,         32'd0,         1'b1, EXC_LAT32);
    run_op("sdiv min/-1",    0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0,         1'b1, EXC_LAT32);
    run_op("udiv 200/7 w8",  1, 1'b1, 1'b0, 32'd200,       32'd7,         1'b0, 32'd28,        32'd4,         1'b0, 9);
    run_op("smul -128*-1 w8",1, 1'b0, 1'b1, 32'h80,        32'hFF,        1'b0, 32'h80,        32'h00,        1'b1, 9);
    run_op("sdiv min/-1 w8", 1, 1'b1, 1'b1, 32'h80,        32'hFF,        1'b0, 32'h80,        32'h00,        1'b1, EXC_LAT8);
    run_op("sdiv 100/-9 w8", 1, 1'b1, 1'b1, 32'd100,       32'hF7,        1'b0, 32'hF5,        32'h01,        1'b0, 9);

    // New start issued in the very cycle the previous strobe is high.
    run_op("umul 3*5",       0, 1'b0, 1'b0, 32'd3,         32'd5,         1'b0, 32'd15,        32'd0,         1'b0, 33);
    run_op("b2b umul 9*9",   0, 1'b0, 1'b0, 32'd9,         32'd9,         1'b1, 32'd81,        32'd0,         1'b0, 33);

    // Multiply launched ten cycles into a divide replaces it.
    issue(0, 1'b1, 1'b0, 32'd1000, 32'd7, 1'b0);
    n_rdy = 0;
    repeat (9) begin
      @(negedge clock);
      if (rdy_w[0] === 1'b1) n_rdy++;
    end
    check("restart early strobes", 64'(n_rdy), 64'd0);
    run_op("restart umul 5*6", 0, 1'b0, 1'b0, 32'd5, 32'd6, 1'b0, 32'd30, 32'd0, 1'b0, 33);

    // Both start pulses together are ignored.
    @(posedge clock);
    #1 mult_in[0] = 1'b1; div_in[0] = 1'b1; op_a[0] = 32'd11; op_b[0] = 32'd3;
    @(posedge clock);
    #1 mult_in[0] = 1'b0; div_in[0] = 1'b0;
    n_rdy = 0; n_busy = 0;
    repeat (40) begin
      @(negedge clock);
      if (rdy_w[0] === 1'b1)  n_rdy++;
      if (busy_w[0] === 1'b1) n_busy++;
    end
    check("both-high strobes", 64'(n_rdy),  64'd0);
    check("both-high busy",    64'(n_busy), 64'd0);

    // Reset in the middle of an operation.
    issue(0, 1'b0, 1'b0, 32'h1234, 32'd3, 1'b0);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid-op reset lo",   64'(res_w[0]),  64'd0);
    check("mid-op reset hi",   64'(hi_w[0]),   64'd0);
    check("mid-op reset busy", 64'(busy_w[0]), 64'd0);
    n_rdy = 0;
    repeat (40) begin
      @(negedge clock);
      if (rdy_w[0] === 1'b1) n_rdy++;
    end
    check("mid-op reset strobes", 64'(n_rdy), 64'd0);

    // Random traffic with restarts, ignored double pulses and rare resets.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      reset = ($urandom_range(0, 1499) == 0);
      for (int i = 0; i < 2; i++) begin
        r          = int'($urandom_range(0, (i == 0) ? 79 : 24));
        mult_in[i] = (r == 0) || (r == 2);
        div_in[i]  = (r == 1) || (r == 2);
        sgn_in[i]  = 1'($urandom_range(0, 1));
        op_a[i]    = pick(width_of(i));
        op_b[i]    = pick(width_of(i));
      end
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mult_in[i] = 1'b0; div_in[i] = 1'b0;
    end
    repeat (40) @(posedge clock);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Parametrised sequential multiply/divide unit for the processor's execute stage, the next generation of the fixed 32-bit multdiv. One shared iterative datapath does signed or unsigned WIDTH-bit multiply (radix-2 shift-add) and divide (non-restoring). A start pulse launches an operation, and a one-cycle ready strobe returns low result, high result, and exception. The unit adds explicit reset, a busy flag, unsigned mode, and a full-width high result (upper product half or remainder).

## Interface
- WIDTH, 32: operand and result width; must be ≥ 4.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only on start cycle.
- data_operandB  in  WIDTH  multiplier / divisor; sampled only on start cycle.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- ctrl_signed  in  1  1 = two's-complement operands; 0 = unsigned. Sampled on start cycle.
- data_result  out  WIDTH  low product half / quotient.
- data_result_hi  out  WIDTH  high product half / remainder.
- data_exception  out  1  overflow or divide error; valid while data_resultRDY = 1.
- data_resultRDY  out  1  one-cycle completion strobe.
- busy  out  1  operation in progress.

## Operation
- States: IDLE, RUN, DONE.
- Start cycle: ctrl_MULT XOR ctrl_DIV sampled high at a rising edge. Operands, op, and sign mode are latched, and the state moves to RUN with counter = WIDTH.
- If both ctrl_MULT and ctrl_DIV are high, the start is ignored and state is unchanged.
- A start while in RUN or DONE aborts the current operation and restarts with the new operands. No ready strobe is issued for the aborted op.
- Signed mode: operands are converted to magnitudes at start, and result signs are fixed in DONE.
  - Product sign = sign A XOR sign B.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- RUN: one shift-add or shift-subtract step per cycle. The counter decrements, and at 0 the state goes to DONE.
- DONE: non-restoring remainder correction, sign fix-up, and exception computation. The registered outputs are loaded, data_resultRDY is pulsed, and the state returns to IDLE.
- Multiply exception:
  - Signed: the 2·WIDTH product is not a sign extension of data_result.
  - Unsigned: data_result_hi ≠ 0.
  - Both result halves are still returned.
- Divide by zero: exception = 1, data_result = 0, data_result_hi = 0.
- Signed MIN / −1: exception = 1, data_result = MIN, data_result_hi = 0.
- data_result, data_result_hi, and data_exception hold their last values until the next completion. There is no tri-state output; all outputs are registered.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts it at that edge. No strobe is issued.
- Start sampled at edge k:
  - busy = 1 from after edge k until after edge k+WIDTH+1.
  - Outputs update, data_resultRDY = 1, and busy = 0 after edge k+WIDTH+1. Latency is WIDTH+1 cycles.
- data_resultRDY is high for exactly one cycle per completed op.
- A new start may be sampled in the same cycle data_resultRDY is high; the next op begins normally.
- Operand inputs are don't-care outside the start cycle.

## Configuration
- MULTDIV_SEQ_FAST_EXC_EN
  - Defined: a divide with B = 0, or a signed MIN / −1, skips RUN and goes directly IDLE→DONE. data_resultRDY is asserted after edge k+1 (latency 1) with the exception values above, and busy is high for one cycle.
  - Undefined: these cases run the full WIDTH+1 latency and produce the same output values.
- All other operations are unaffected.

## Test plan
- WIDTH=32, signed MULT 7 × −3: strobe at k+33 with data_result = 0xFFFFFFEB, data_result_hi = 0xFFFFFFFF, exception = 0.
- WIDTH=32, unsigned MULT 0x10000 × 0x10000: data_result = 0, data_result_hi = 1, exception = 1.
- WIDTH=32, signed DIV −7 / 2: data_result = −3, data_result_hi = −1, exception = 0. Repeat with B = 0: exception = 1 and both results 0. Check latency 33 without the macro and 1 with it.
- WIDTH=32, signed DIV 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000, data_result_hi = 0, exception = 1.
- Restart and simultaneous events:
  - ctrl_MULT pulse 10 cycles into a DIV: only one strobe, at restart+33, carrying the MULT result.
  - ctrl_MULT and ctrl_DIV both high: no busy, no strobe.
  - reset mid-op: all outputs 0 next cycle, no strobe.
- WIDTH=8, unsigned DIV 200 / 7 and signed MULT −128 × −1:
  - DIV: result 28, data_result_hi 4, latency 9.
  - MULT: data_result = 0x80, data_result_hi = 0x00, exception = 1.
